codec_spi_cfg_seq: RTL and testbench

Sequencer that configures the audio codec over its SPI control port after reset, as the codec programming step ahead of I2S streaming. It walks an external register table of NUM_REGS 16-bit entries, shifts each entry out as one SPI frame and reports completion. With readback compiled in, it reads each register back and flags the first mismatch. It sits between the board reset-delay logic and the codec SPI pins (SS_n, SCLK, MOSI, MISO).

---
 rtl/codec_spi_cfg_seq_if.sv | 32 +++
 rtl/codec_spi_cfg_seq.sv | 181 ++++++++++++++++++
 tb/tb_codec_spi_cfg_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/codec_spi_cfg_seq_if.sv
`default_nettype none
// =============================================================================
// codec_spi_cfg_seq_if : register-table lookup and codec SPI pins
// Rev 1.0
// =============================================================================
interface codec_spi_cfg_seq_if;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        output tbl_addr,
        input  tbl_data,
        output spi_cs_n,
        output spi_sclk,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  tbl_addr,
        output tbl_data,
        input  spi_cs_n,
        input  spi_sclk,
        input  spi_mosi,
        output spi_miso
    );
endinterface
`default_nettype wire

// File: rtl/codec_spi_cfg_seq.sv
`default_nettype none
// =============================================================================
// codec_spi_cfg_seq : post-reset codec register programming over SPI (CPOL=0).
// Optional readback/verify when CODEC_SPI_READBACK_EN is defined.  Rev 1.0
// =============================================================================
module codec_spi_cfg_seq #(
    parameter int NUM_REGS = 8,
    parameter int CLK_DIV  = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    codec_spi_cfg_seq_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [6:0]           err_index
);

    localparam int             CW         = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0]  C_DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  C_GAP_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);
    localparam logic [6:0]     C_LAST_IDX = 7'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5,
        S_CHECK = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic           r_phase;
    logic [3:0]     r_bit;
    logic [15:0]    r_sr;
    logic [6:0]     r_idx;
    logic           r_rd;
    logic           r_done;
    logic           w_div_end;
    logic           w_gap_end;
    logic           w_last;
    logic           w_step;
    logic           w_done_set;

    assign w_div_end = (r_cnt == C_DIV_LAST);
    assign w_gap_end = (r_cnt == C_GAP_LAST);
    assign w_last    = (r_idx == C_LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        w_step       = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            S_IDLE:  if (start && !r_done) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_SETUP;
            S_SETUP: if (w_div_end) w_state_next = S_SHIFT;
            S_SHIFT: if (w_div_end && r_phase && (r_bit == 4'd15)) w_state_next = S_HOLD;
            S_HOLD:  if (w_div_end) w_state_next = S_GAP;
            S_GAP: begin
                if (w_gap_end) begin
`ifdef CODEC_SPI_READBACK_EN
                    w_state_next = r_rd ? S_CHECK : S_LOAD;
`else
                    w_step = 1'b1;
`endif
                end
            end
            S_CHECK: w_step = 1'b1;
            default: w_state_next = S_IDLE;
        endcase
        // Common "next entry or finish" decision shared by GAP and CHECK.
        if (w_step) begin
            if (w_last) begin
                w_state_next = S_IDLE;
                w_done_set   = 1'b1;
            end else begin
                w_state_next = S_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_bit   <= 4'd0;
            r_sr    <= 16'h0000;
            r_idx   <= 7'd0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_set;

            // One timer serves every state; SHIFT restarts it each half-period.
            if ((w_state_next != r_state) || ((r_state == S_SHIFT) && w_div_end))
                r_cnt <= '0;
            else if (r_state != S_IDLE)
                r_cnt <= r_cnt + C_CNT_ONE;

            if (r_state == S_LOAD) begin
                r_sr    <= r_rd ? {bus.tbl_data[15:9], 1'b1, 8'h00} : bus.tbl_data;
                r_phase <= 1'b0;
                r_bit   <= 4'd0;
            end else if ((r_state == S_SHIFT) && w_div_end) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_bit <= r_bit + 4'd1;
                    r_sr  <= {r_sr[14:0], 1'b0};
                end
            end

            if (w_step && !w_last)
                r_idx <= r_idx + 7'd1;
            else if (w_state_next == S_IDLE)
                r_idx <= 7'd0;
        end
    end

`ifdef CODEC_SPI_READBACK_EN
    logic [7:0] r_rx;
    logic       r_error;
    logic [6:0] r_err_index;
    logic       w_accept;
    logic       w_to_read;

    assign w_accept  = (r_state == S_IDLE) && start && !r_done;
    assign w_to_read = (r_state == S_GAP) && w_gap_end && !r_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd        <= 1'b0;
            r_rx        <= 8'h00;
            r_error     <= 1'b0;
            r_err_index <= 7'd0;
        end else begin
            if (w_to_read)
                r_rd <= 1'b1;
            else if (w_step)
                r_rd <= 1'b0;

            // Sample on the clk edge that raises SCLK; codec reply lands in the last 8 bits.
            if ((r_state == S_SHIFT) && w_div_end && !r_phase)
                r_rx <= {r_rx[6:0], bus.spi_miso};

            if (w_accept) begin
                r_error     <= 1'b0;
                r_err_index <= 7'd0;
            end else if ((r_state == S_CHECK) && (r_rx != bus.tbl_data[7:0]) && !r_error) begin
                r_error     <= 1'b1;
                r_err_index <= r_idx;
            end
        end
    end

    assign error     = r_error;
    assign err_index = r_err_index;
`else
    logic unused_miso;

    assign r_rd        = 1'b0;
    assign error       = 1'b0;
    assign err_index   = 7'd0;
    assign unused_miso = bus.spi_miso;
`endif

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign bus.tbl_addr = r_idx;
    assign bus.spi_cs_n = !((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD));
    assign bus.spi_sclk = (r_state == S_SHIFT) && r_phase;
    assign bus.spi_mosi = ((r_state == S_SETUP) || (r_state == S_SHIFT)) ? r_sr[15] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_codec_spi_cfg_seq.sv
`default_nettype none
// Directed bench for codec_spi_cfg_seq: frame scoreboard on MOSI, MISO echo model,
// done latency, readback error reporting, reset and start-while-busy behaviour.
module tb_codec_spi_cfg_seq;

    localparam int NUM_REGS = 3;
    localparam int CLK_DIV  = 2;
    localparam int FRAME    = 1 + 36 * CLK_DIV;
`ifdef CODEC_SPI_READBACK_EN
    localparam int FPE      = 2;
    localparam int SEQ_LAT  = NUM_REGS * (2 * FRAME + 1);
`else
    localparam int FPE      = 1;
    localparam int SEQ_LAT  = NUM_REGS * FRAME;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       error;
    logic [6:0] err_index;

    codec_spi_cfg_seq_if bus ();

    codec_spi_cfg_seq #(
        .NUM_REGS (NUM_REGS),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    always #5 clk = ~clk;

    logic [15:0]         tbl [NUM_REGS] = '{16'h0A55, 16'h1281, 16'hFE00};
    logic [NUM_REGS-1:0] bad = '0;

    assign bus.tbl_data = (bus.tbl_addr < 7'(NUM_REGS)) ? tbl[bus.tbl_addr[1:0]] : 16'h0000;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] word;
        logic [6:0]  idx;
    } frame_t;

    frame_t exp_q[$];
    int     n_assert = 0;
    int     n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bus monitor and codec model, evaluated mid-cycle.
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;
    logic        prev_mosi = 1'b0;
    logic [15:0] shreg     = 16'h0000;
    logic [15:0] reply;
    int          rises     = 0;
    int          frames    = 0;
    int          rises_all = 0;
    frame_t      f;

    always @(negedge clk) begin
        if (bus.spi_sclk && !prev_sclk) rises_all++;
        if (!rst_n) begin
            rises        = 0;
            shreg        = 16'h0000;
            prev_cs      = 1'b1;
            bus.spi_miso = 1'b0;
        end else begin
            if (bus.spi_sclk && !prev_sclk) begin
                shreg = {shreg[14:0], bus.spi_mosi};
                rises++;
            end
            if (bus.spi_sclk && prev_sclk && (bus.spi_mosi !== prev_mosi))
                chk("mosi_stable_while_sclk_high", 32'(bus.spi_mosi), 32'(prev_mosi));
            if (bus.spi_cs_n && !prev_cs) begin
                frames++;
                chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    f = exp_q.pop_front();
                    chk("frame_word", 32'(shreg), 32'(f.word));
                    chk("frame_sclk_rises", 32'(rises), 32'd16);
                    chk("frame_tbl_addr", 32'(bus.tbl_addr), 32'(f.idx));
                end
                rises = 0;
            end
            reply = 16'h0000;
            if (bus.tbl_addr < 7'(NUM_REGS))
                reply[7:0] = bad[bus.tbl_addr[1:0]] ? 8'h00 : tbl[bus.tbl_addr[1:0]][7:0];
            bus.spi_miso = (rises < 16) ? reply[15 - rises] : 1'b0;
            prev_cs = bus.spi_cs_n;
        end
        prev_sclk = bus.spi_sclk;
        prev_mosi = bus.spi_mosi;
    end

    task automatic run_seq(input logic [NUM_REGS-1:0] badmask, input bit mid_start, input string name);
        int          start_edge;
        int          frames_base;
        int          waited;
        logic        exp_err;
        logic [6:0]  exp_idx;
        bad         = badmask;
        exp_err     = 1'b0;
        exp_idx     = 7'd0;
        frames_base = frames;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back('{tbl[i], 7'(i)});
`ifdef CODEC_SPI_READBACK_EN
            exp_q.push_back('{{tbl[i][15:9], 1'b1, 8'h00}, 7'(i)});
            if (badmask[i] && (tbl[i][7:0] != 8'h00) && !exp_err) begin
                exp_err = 1'b1;
                exp_idx = 7'(i);
            end
`endif
        end
        start      = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk({name, ":busy_after_start"}, 32'(busy), 32'd1);
        chk({name, ":tbl_addr_first"}, 32'(bus.tbl_addr), 32'd0);
        if (mid_start) begin
            waited = 0;
            while ((frames - frames_base) < 1 && waited < 2 * FRAME) begin
                @(negedge clk);
                waited++;
            end
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (!done && waited < SEQ_LAT + 200) begin
            @(negedge clk);
            waited++;
        end
        chk({name, ":done_seen"}, 32'(done), 32'd1);
        chk({name, ":done_latency"}, 32'(cyc - start_edge), 32'(SEQ_LAT));
        chk({name, ":busy_at_done"}, 32'(busy), 32'd0);
        chk({name, ":frame_count"}, 32'(frames - frames_base), 32'(FPE * NUM_REGS));
        chk({name, ":scoreboard_drained"}, 32'(exp_q.size()), 32'd0);
        chk({name, ":error"}, 32'(error), 32'(exp_err));
        chk({name, ":err_index"}, 32'(err_index), 32'(exp_idx));
        @(negedge clk);
        chk({name, ":done_one_cycle"}, 32'(done), 32'd0);
        chk({name, ":tbl_addr_idle"}, 32'(bus.tbl_addr), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst:cs_n", 32'(bus.spi_cs_n), 32'd1);
        chk("rst:sclk", 32'(bus.spi_sclk), 32'd0);
        chk("rst:mosi", 32'(bus.spi_mosi), 32'd0);
        chk("rst:tbl_addr", 32'(bus.tbl_addr), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:error", 32'(error), 32'd0);
        chk("rst:err_index", 32'(err_index), 32'd0);
        chk("rst:no_sclk_edges", 32'(rises_all), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_seq('0, 1'b0, "seq_echo");
        repeat (3) @(negedge clk);
        run_seq(3'b110, 1'b0, "seq_mismatch");
        repeat (3) @(negedge clk);
        run_seq('0, 1'b1, "seq_mid_start");
        repeat (3) @(negedge clk);

        // Abort a frame in SHIFT with reset.
        bad   = '0;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (rises < 3 && waited < 2 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        chk("abort:reached_shift", 32'(rises >= 3), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort:cs_n", 32'(bus.spi_cs_n), 32'd1);
        chk("abort:sclk", 32'(bus.spi_sclk), 32'd0);
        chk("abort:busy", 32'(busy), 32'd0);
        chk("abort:tbl_addr", 32'(bus.tbl_addr), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        run_seq('0, 1'b0, "seq_after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
